// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter sharing one RAM slot per cycle between video and CPU
module vram_arbiter #(
  parameter int AW      = 13,
  parameter int DW      = 8,
  parameter int MAXWAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vga_addr,
  output logic [DW-1:0] vga_data,
  output logic          vid_miss,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_busy,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MAXWAIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic [AW-1:0]   pend_addr;
  logic            pend_we;
  logic [DW-1:0]   pend_wdata;
  logic            vid_slot_q;
  logic [DW-1:0]   vga_q;

  logic            issue;
  logic            issue_we;
  logic [AW-1:0]   issue_addr;
  logic [DW-1:0]   issue_wdata;
  logic            vid_slot;

  // The CPU wins the slot in IDLE only when video is quiet; in PEND it also
  // wins once it has waited MAXWAIT cycles, stealing the video slot.
  always_comb begin
    issue       = 1'b0;
    issue_we    = cpu_we;
    issue_addr  = cpu_addr;
    issue_wdata = cpu_wdata;
    case (state)
      IDLE: begin
        issue = cpu_req && !vid_req;
      end
      PEND: begin
        issue       = !vid_req || (wait_cnt == CW'(MAXWAIT));
        issue_we    = pend_we;
        issue_addr  = pend_addr;
        issue_wdata = pend_wdata;
      end
      default: begin
        issue = 1'b0;
      end
    endcase
    if (reset) begin
      issue = 1'b0;
    end
  end

  assign vid_slot  = vid_req && !issue && !reset;
  assign mem_addr  = issue ? issue_addr : vga_addr;
  assign mem_we    = issue && issue_we;
  assign mem_wdata = issue ? issue_wdata : '0;
  assign cpu_busy  = (state != IDLE) && !reset;

  // The RAM answers one cycle late, so the fresh word is forwarded directly
  // and the register only serves the cycles after that.
  assign vga_data  = vid_slot_q ? mem_rdata : vga_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      pend_addr  <= '0;
      pend_we    <= 1'b0;
      pend_wdata <= '0;
      cpu_ack    <= 1'b0;
      vid_miss   <= 1'b0;
      cpu_rdata  <= '0;
      vid_slot_q <= 1'b0;
      vga_q      <= '0;
    end else begin
      cpu_ack    <= 1'b0;
      vid_miss   <= issue && vid_req;
      vid_slot_q <= vid_slot;
      if (vid_slot_q) begin
        vga_q <= mem_rdata;
      end
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (!vid_req) begin
              if (cpu_we) begin
                cpu_ack <= 1'b1;
              end else begin
                state <= RDWAIT;
              end
            end else begin
              pend_addr  <= cpu_addr;
              pend_we    <= cpu_we;
              pend_wdata <= cpu_wdata;
              wait_cnt   <= CW'(1);
              state      <= PEND;
            end
          end
        end
        PEND: begin
          if (issue) begin
            wait_cnt <= '0;
            if (pend_we) begin
              cpu_ack <= 1'b1;
              state   <= IDLE;
            end else begin
              state <= RDWAIT;
            end
          end else if (wait_cnt != CW'(MAXWAIT)) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RDWAIT: begin
          cpu_rdata <= mem_rdata;
          cpu_ack   <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - scoreboard bench for vram_arbiter with a transaction-level reference model
module tb_vram_arbiter;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int MW = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic [DW-1:0] vga_data;
  logic          vid_miss;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_busy;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  vram_arbiter #(.AW(AW), .DW(DW), .MAXWAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vga_addr(vga_addr), .vga_data(vga_data), .vid_miss(vid_miss),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [DW-1:0] data; bit is_read; } ack_t;
  typedef struct { int cyc; logic [DW-1:0] data; } vga_t;
  typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;

  ack_t ack_q[$];
  vga_t vga_q[$];
  wr_t  wr_q[$];
  int   miss_q[$];

  int nchecks = 0;
  int nerr = 0;
  logic [DW-1:0] vga_cur = '0;
  logic [AW-1:0] addr_set [6] = '{13'h0000, 13'h1800, 13'h0100, 13'h0001, 13'h1fff, 13'h0abc};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    nchecks++;
    nerr++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return addr_set[$urandom_range(0, 5)];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Video side of the model: a slot reads the current memory image, a slot
  // lost to the CPU leaves the previous picture data in place.
  task automatic drive_cycle(input bit v, input logic [AW-1:0] va, input bit cpu_issue);
    vid_req  = v;
    vga_addr = va;
    if (v && !cpu_issue) begin
      vga_q.push_back('{cyc + 1, shadow[va]});
      vga_cur = shadow[va];
    end else if (v && cpu_issue) begin
      miss_q.push_back(cyc + 1);
      vga_q.push_back('{cyc + 1, vga_cur});
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), rand_addr(), 1'b0);
      cpu_req = 1'b0;
      tick();
    end
  endtask

  // One CPU access: the issue cycle is the first quiet video cycle, capped
  // at MW cycles after the request; the ack follows 1 (write) or 2 (read) later.
  task automatic do_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int nlead, input int density, input bit spurious);
    bit vid [MW+3];
    int k;
    int ackj;
    int c0;
    bit found;
    for (int j = 0; j < MW + 3; j++)
      vid[j] = (j < nlead) ? 1'b1 : ($urandom_range(0, 99) < density);
    k = MW;
    found = 1'b0;
    for (int j = 0; j < MW; j++) begin
      if (!found && !vid[j]) begin
        k = j;
        found = 1'b1;
      end
    end
    ackj = k + (we ? 1 : 2);
    c0 = cyc;
    for (int j = 0; j < ackj; j++) begin
      drive_cycle(vid[j], rand_addr(), j == k);
      if (j == 0) begin
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      end else begin
        chk("cpu_busy_during_op", {31'd0, cpu_busy}, 32'd1);
        cpu_req   = spurious && ($urandom_range(0, 1) == 1);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = rand_addr();
        cpu_wdata = DW'($urandom);
      end
      if (j == k) begin
        if (we) begin
          wr_q.push_back('{cyc, a, d});
          shadow[a] = d;
          ack_q.push_back('{c0 + ackj, '0, 1'b0});
        end else begin
          ack_q.push_back('{c0 + ackj, shadow[a], 1'b1});
        end
      end
      tick();
    end
    cpu_req = 1'b0;
    chk("cpu_busy_at_ack", {31'd0, cpu_busy}, 32'd0);
  endtask

  task automatic reset_mid(input bit rd_case);
    logic [AW-1:0] a;
    a = rand_addr();
    if (rd_case) begin
      drive_cycle(1'b0, rand_addr(), 1'b0);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
      tick();
    end else begin
      drive_cycle(1'b1, rand_addr(), 1'b0);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = DW'($urandom);
      tick();
      drive_cycle(1'b1, rand_addr(), 1'b0);
      cpu_req = 1'b0;
      tick();
    end
    cpu_req = 1'b0;
    vid_req = 1'b0;
    reset   = 1'b1;
    vga_cur = '0;
    tick();
    tick();
    reset = 1'b0;
    drive_cycle(1'b0, rand_addr(), 1'b0);
    vga_q.push_back('{cyc, '0});
    chk("busy_after_reset", {31'd0, cpu_busy}, 32'd0);
    tick();
  endtask

  // Monitor: compares DUT outputs against the queued expectations each cycle.
  always @(negedge clk) begin
    if (cpu_ack) begin
      if (ack_q.size() == 0) fail("unexpected_cpu_ack");
      else begin
        ack_t e;
        e = ack_q.pop_front();
        chk("ack_cycle", cyc, e.cyc);
        if (e.is_read) chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, e.data});
      end
    end else if (ack_q.size() != 0 && ack_q[0].cyc <= cyc) begin
      void'(ack_q.pop_front());
      fail("missing_cpu_ack");
    end

    if (vid_miss) begin
      if (miss_q.size() == 0) fail("unexpected_vid_miss");
      else chk("vid_miss_cycle", cyc, miss_q.pop_front());
    end else if (miss_q.size() != 0 && miss_q[0] <= cyc) begin
      void'(miss_q.pop_front());
      fail("missing_vid_miss");
    end

    if (mem_we) begin
      if (wr_q.size() == 0) fail("unexpected_mem_we");
      else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("write_cycle", cyc, w.cyc);
        chk("write_addr", {19'd0, mem_addr}, {19'd0, w.addr});
        chk("write_data", {24'd0, mem_wdata}, {24'd0, w.data});
      end
    end else if (wr_q.size() != 0 && wr_q[0].cyc <= cyc) begin
      void'(wr_q.pop_front());
      fail("missing_mem_write");
    end

    while (vga_q.size() != 0 && vga_q[0].cyc < cyc) begin
      void'(vga_q.pop_front());
      fail("vga_expectation_skipped");
    end
    if (vga_q.size() != 0 && vga_q[0].cyc == cyc) begin
      vga_t v;
      v = vga_q.pop_front();
      chk("vga_data", {24'd0, vga_data}, {24'd0, v.data});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = DW'($urandom);
      shadow[i] = ram[i];
    end
    ram[13'h0000] = 8'h11; shadow[13'h0000] = 8'h11;
    ram[13'h1800] = 8'h22; shadow[13'h1800] = 8'h22;

    reset = 1'b1;
    tick(); tick(); tick();
    chk("reset_busy", {31'd0, cpu_busy}, 32'd0);
    chk("reset_ack", {31'd0, cpu_ack}, 32'd0);
    chk("reset_miss", {31'd0, vid_miss}, 32'd0);
    chk("reset_rdata", {24'd0, cpu_rdata}, 32'd0);
    chk("reset_vga", {24'd0, vga_data}, 32'd0);
    chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    reset = 1'b0;

    drive_cycle(1'b1, 13'h0000, 1'b0); tick();
    drive_cycle(1'b1, 13'h1800, 1'b0); tick();
    drive_cycle(1'b0, 13'h0000, 1'b0); tick();
    drive_cycle(1'b0, 13'h0000, 1'b0); tick();

    do_op(1'b1, 13'h0100, 8'h5A, 0, 0, 1'b0);
    do_op(1'b0, 13'h0100, 8'h00, 0, 0, 1'b0);
    do_op(1'b0, 13'h1800, 8'h00, 3, 0, 1'b0);
    do_op(1'b1, 13'h0abc, 8'hC3, MW + 3, 100, 1'b1);
    do_op(1'b0, 13'h0abc, 8'h00, MW + 3, 100, 1'b1);
    idle_cycles(2);

    reset_mid(1'b0);
    reset_mid(1'b1);

    for (int n = 0; n < 150; n++) begin
      int nlead;
      int dens;
      nlead = ($urandom_range(0, 9) == 0) ? MW + 3 : $urandom_range(0, 3);
      case ($urandom_range(0, 2))
        0: dens = 0;
        1: dens = 30;
        default: dens = 70;
      endcase
      do_op(1'($urandom_range(0, 1)), rand_addr(), DW'($urandom), nlead, dens,
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end

    vid_req = 1'b0;
    repeat (4) tick();
    chk("ack_queue_drained", ack_q.size(), 0);
    chk("miss_queue_drained", miss_q.size(), 0);
    chk("write_queue_drained", wr_q.size(), 0);
    chk("vga_queue_drained", vga_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
